// File: rtl/ifetch.sv
// Instruction fetch stage: owns the fetch PC, issues halfword reads and
// buffers returned halfwords in a small prefetch queue for decode.
module ifetch #(
  parameter int MEM_DEPTH = 2**12,
  parameter int QUEUE_DEPTH = 2,
  parameter int RESET_PC = 0,
  localparam int ADDR_WIDTH = $clog2(MEM_DEPTH*2)
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_en,
  output logic                  o_mem_rd_en,
  input  logic [0:1][7:0]       i_mem_do,
  input  logic                  i_stall,
  input  logic                  i_branch_en,
  input  logic [ADDR_WIDTH-1:0] i_branch_target,
  output logic [0:1][7:0]       o_ir,
  output logic [ADDR_WIDTH-1:0] o_ir_pc,
  output logic                  o_ir_valid,
  input  logic                  i_ir_ready
);

  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int OCC_W = CNT_W + 1;

  localparam logic [ADDR_WIDTH-1:0] RST_PC =
    ADDR_WIDTH'(RESET_PC) & ~ADDR_WIDTH'(1);

  typedef struct packed {
    logic [0:1][7:0]       ir;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  entry_t                q [QUEUE_DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  inflight;
  logic [ADDR_WIDTH-1:0] pc_q;
  logic [ADDR_WIDTH-1:0] req_pc;

  logic             pop;
  logic             push;
  logic             discard;
  logic             issue;
  logic             full;
  logic [OCC_W-1:0] occ;

  assign o_ir_valid = (count != '0);
  assign pop        = o_ir_valid & i_ir_ready;
  assign full       = (count == CNT_W'(QUEUE_DEPTH));

  // A redirect kills the response landing this cycle.
  assign discard = i_branch_en;
  assign push    = inflight & ~discard;

  assign occ = {1'b0, count}
             + OCC_W'(inflight)
             - OCC_W'(pop);

  assign issue = ~rst & ~i_stall & ~i_branch_en
               & (occ < OCC_W'(QUEUE_DEPTH));

  assign o_mem_addr  = pc_q;
  assign o_mem_en    = issue;
  assign o_mem_rd_en = issue;

  assign o_ir    = q[rd_ptr].ir;
  assign o_ir_pc = q[rd_ptr].pc;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q     <= RST_PC;
      req_pc   <= '0;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      for (int i = 0; i < QUEUE_DEPTH; i++) begin
        q[i] <= '0;
      end
    end else begin
      inflight <= issue;
      if (issue) begin
        req_pc <= pc_q;
      end
      if (i_branch_en) begin
        pc_q <= i_branch_target & ~ADDR_WIDTH'(1);
      end else if (issue) begin
        pc_q <= pc_q + ADDR_WIDTH'(2);
      end
      if (i_branch_en) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push) begin
          q[wr_ptr] <= '{ir: i_mem_do, pc: req_pc};
          wr_ptr    <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
        count <= count + CNT_W'(push) - CNT_W'(pop);
      end
    end
  end

  // Issue is throttled on occupancy, so a push never lands on a full queue.
  a_no_overflow: assert property (
    @(posedge clk) disable iff (rst)
    !(push && full && !pop)
  );

endmodule

// File: tb/tb_ifetch.sv
// Testbench for ifetch: directed scenarios plus a randomized phase,
// each pop checked against an in-order fetch-stream model.
module tb_ifetch;

  localparam int AW = 13;
  localparam logic [AW-1:0] RST = '0;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] o_mem_addr;
  logic          o_mem_en;
  logic          o_mem_rd_en;
  logic [0:1][7:0] i_mem_do;
  logic          i_stall;
  logic          i_branch_en;
  logic [AW-1:0] i_branch_target;
  logic [0:1][7:0] o_ir;
  logic [AW-1:0] o_ir_pc;
  logic          o_ir_valid;
  logic          i_ir_ready;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] exp_pc;
  logic          prev_hold;
  logic [AW-1:0] prev_pc;
  logic [15:0]   prev_ir;
  int            n_issue;
  int            n_pop;

  always #5 clk = ~clk;

  ifetch dut (
    .clk(clk),
    .rst(rst),
    .o_mem_addr(o_mem_addr),
    .o_mem_en(o_mem_en),
    .o_mem_rd_en(o_mem_rd_en),
    .i_mem_do(i_mem_do),
    .i_stall(i_stall),
    .i_branch_en(i_branch_en),
    .i_branch_target(i_branch_target),
    .o_ir(o_ir),
    .o_ir_pc(o_ir_pc),
    .o_ir_valid(o_ir_valid),
    .i_ir_ready(i_ir_ready)
  );

  function automatic logic [15:0] mdata(input logic [AW-1:0] a);
    return 16'(a >> 1) ^ 16'hC3A0;
  endfunction

  always @(posedge clk) begin
    if (o_mem_en) i_mem_do <= mdata(o_mem_addr);
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Stream model: every delivered halfword must be the next one in
  // program order; a redirect restarts the order at the aligned target.
  task automatic tick();
    @(negedge clk);
    if (rst) begin
      exp_pc    = RST;
      prev_hold = 1'b0;
      n_issue   = 0;
      n_pop     = 0;
    end else begin
      if (i_stall || i_branch_en) chk("no_issue", o_mem_en, 0);
      if (o_mem_en) begin
        chk("addr_lsb", o_mem_addr[0], 0);
        n_issue++;
      end
      if (prev_hold) begin
        chk("hold_valid", o_ir_valid, 1);
        chk("hold_pc", o_ir_pc, prev_pc);
        chk("hold_ir", o_ir, prev_ir);
      end
      if (o_ir_valid && i_ir_ready) begin
        chk("pop_pc", o_ir_pc, exp_pc);
        chk("pop_ir", o_ir, mdata(exp_pc));
        exp_pc = exp_pc + AW'(2);
        n_pop++;
      end
      prev_hold = o_ir_valid && !i_ir_ready && !i_branch_en;
      prev_pc   = o_ir_pc;
      prev_ir   = o_ir;
      if (i_branch_en) exp_pc = i_branch_target & ~AW'(1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [AW-1:0] tgt,
                          input string tag);
    i_branch_en = 1'b1;
    i_branch_target = tgt;
    i_ir_ready = 1'b1;
    tick();
    i_branch_en = 1'b0;
    #1;
    chk({tag, "_b1_valid"}, o_ir_valid, 0);
    chk({tag, "_b1_issue"}, o_mem_en, 1);
    chk({tag, "_b1_addr"}, o_mem_addr, tgt & ~AW'(1));
    tick();
    chk({tag, "_b2_valid"}, o_ir_valid, 0);
    tick();
    chk({tag, "_b3_valid"}, o_ir_valid, 1);
    chk({tag, "_b3_pc"}, o_ir_pc, tgt & ~AW'(1));
  endtask

  initial begin
    rst = 1'b1;
    i_stall = 1'b0;
    i_branch_en = 1'b0;
    i_branch_target = '0;
    i_ir_ready = 1'b1;
    exp_pc = RST;
    prev_hold = 1'b0;
    prev_pc = '0;
    prev_ir = '0;
    n_issue = 0;
    n_pop = 0;
    @(posedge clk);
    #1;
    tick();
    tick();
    chk("rst_valid", o_ir_valid, 0);
    chk("rst_en", o_mem_en, 0);
    chk("rst_rd_en", o_mem_rd_en, 0);
    chk("rst_ir", o_ir, 0);
    chk("rst_pc", o_ir_pc, 0);

    // First fetch and its latency, then sequential stream
    rst = 1'b0;
    #1;
    chk("t1_issue", o_mem_en, 1);
    chk("t1_rd_en", o_mem_rd_en, 1);
    chk("t1_addr", o_mem_addr, 0);
    tick();
    chk("t1_n1_valid", o_ir_valid, 0);
    tick();
    chk("t1_n2_valid", o_ir_valid, 1);
    chk("t1_pc0", o_ir_pc, 0);
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("t1_seq_valid", o_ir_valid, 1);
      chk("t1_seq_pc", o_ir_pc, AW'(2 * k));
    end

    // Decode back-pressure fills the queue
    i_ir_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("t2_mem_idle", o_mem_en, 0);
      chk("t2_valid", o_ir_valid, 1);
      tick();
    end
    chk("t2_buffered", n_issue - n_pop, 2);
    i_ir_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk("t2_resume_valid", o_ir_valid, 1);
      tick();
    end

    // Redirect mid-stream, then from a full queue
    redirect(AW'(16'h0100), "t3");
    tick();
    i_ir_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    redirect(AW'(16'h0200), "t3f");

    // Odd target is aligned
    tick();
    redirect(AW'(16'h00FF), "t4");

    // Sequential fetch wraps at the top of the address space
    redirect(AW'(16'h1FFA), "t5");
    tick();
    chk("t5_pc_1ffc", o_ir_pc, AW'(16'h1FFC));
    tick();
    chk("t5_pc_1ffe", o_ir_pc, AW'(16'h1FFE));
    tick();
    chk("t5_wrap", o_ir_pc, 0);

    // Stall blocks issue while the queue drains, then reset with redirect
    i_stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("t6_stall_en", o_mem_en, 0);
      if (k == 2) chk("t6_drained", o_ir_valid, 0);
      tick();
    end
    i_stall = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    i_branch_en = 1'b1;
    i_branch_target = AW'(16'h0300);
    tick();
    chk("t6_rst_valid", o_ir_valid, 0);
    chk("t6_rst_en", o_mem_en, 0);
    rst = 1'b0;
    i_branch_en = 1'b0;
    #1;
    chk("t6_post_en", o_mem_en, 1);
    chk("t6_post_addr", o_mem_addr, RST);
    tick();
    tick();
    chk("t6_post_valid", o_ir_valid, 1);
    chk("t6_post_pc", o_ir_pc, RST);

    // Randomized traffic against the stream model
    for (int k = 0; k < 3000; k++) begin
      i_ir_ready = ($urandom_range(3) != 0);
      i_stall = ($urandom_range(4) == 0);
      i_branch_en = ($urandom_range(31) == 0);
      i_branch_target = AW'($urandom);
      tick();
    end
    i_ir_ready = 1'b1;
    i_stall = 1'b0;
    i_branch_en = 1'b0;
    for (int w = 0; w < 10 && !o_ir_valid; w++) tick();
    chk("final_live", o_ir_valid, 1);
    for (int k = 0; k < 4; k++) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
